// File: rtl/rv_pkg.sv
// Shared decode types, opcode constants and the immediate builder for the decode stage.
package rv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_XOR    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_AND    = 3'd4,
    ALU_PASS   = 3'd5,
    ALU_MULDIV = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_type_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [3:0]  xfer_size;
    shift_type_e shift_type;
    logic        reg_write;
    logic        alu_src;
    logic        auipc;
    logic        shift;
    logic        slt;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } ctrl_t;

  // Built at 64 bits; narrower datapaths take the low bits.
  function automatic logic [63:0] make_imm(input logic [31:0] instr, input imm_type_e t);
    logic [63:0] imm;
    case (t)
      IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I (+ RV64 LD/SD/LWU) instruction decoder.
// Define RV_M_EXT_EN to accept the M-extension OP encodings (funct7 0000001).
module rv_decoder
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [5:0]  funct6;
  logic        sh_hi_ok;
  logic        illegal;
  imm_type_e   imm_type;
  logic [63:0] imm_full;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign funct6   = instr[31:26];
  // RV32 shift amounts are 5 bits, so bit 25 must be clear there.
  assign sh_hi_ok = (XLEN == 64) ? 1'b1 : !instr[25];

  always_comb begin
    ctrl           = '0;
    ctrl.alu_op    = ALU_ADD;
    ctrl.shift_type = SH_SLL;
    ctrl.xfer_size = 4'd4;
    ctrl.rd        = instr[11:7];
    ctrl.rs1       = instr[19:15];
    ctrl.rs2       = instr[24:20];
    imm_type       = IMM_NONE;
    illegal        = 1'b0;

    case (opcode)
      OPC_LUI: begin
        imm_type = IMM_U; ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_PASS;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U; ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.auipc = 1'b1;
      end
      OPC_JAL: begin
        imm_type = IMM_J; ctrl.reg_write = 1'b1; ctrl.jump = 1'b1;
      end
      OPC_JALR: begin
        imm_type = IMM_I; ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        imm_type = IMM_B; ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB;
        if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
      end
      OPC_LOAD: begin
        imm_type = IMM_I; ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1;
        ctrl.mem_to_reg = 1'b1; ctrl.alu_src = 1'b1;
        case (funct3)
          3'b000, 3'b100: ctrl.xfer_size = 4'd1;
          3'b001, 3'b101: ctrl.xfer_size = 4'd2;
          3'b010:         ctrl.xfer_size = 4'd4;
          3'b011:         if (XLEN == 64) ctrl.xfer_size = 4'd8; else illegal = 1'b1;
          3'b110:         if (XLEN == 64) ctrl.xfer_size = 4'd4; else illegal = 1'b1;
          default:        illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        imm_type = IMM_S; ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1;
        case (funct3)
          3'b000:  ctrl.xfer_size = 4'd1;
          3'b001:  ctrl.xfer_size = 4'd2;
          3'b010:  ctrl.xfer_size = 4'd4;
          3'b011:  if (XLEN == 64) ctrl.xfer_size = 4'd8; else illegal = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        imm_type = IMM_I; ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
        case (funct3)
          3'b000: ctrl.alu_op = ALU_ADD;
          3'b010, 3'b011: begin ctrl.slt = 1'b1; ctrl.alu_op = ALU_SUB; end
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b110: ctrl.alu_op = ALU_OR;
          3'b111: ctrl.alu_op = ALU_AND;
          3'b001: begin
            ctrl.shift = 1'b1; ctrl.shift_type = SH_SLL;
            if (funct6 != 6'b000000 || !sh_hi_ok) illegal = 1'b1;
          end
          default: begin
            ctrl.shift = 1'b1;
            ctrl.shift_type = instr[30] ? SH_SRA : SH_SRL;
            if ((funct6 != 6'b000000 && funct6 != 6'b010000) || !sh_hi_ok) illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000: ctrl.alu_op = ALU_ADD;
              3'b001: begin ctrl.shift = 1'b1; ctrl.shift_type = SH_SLL; end
              3'b010, 3'b011: begin ctrl.slt = 1'b1; ctrl.alu_op = ALU_SUB; end
              3'b100: ctrl.alu_op = ALU_XOR;
              3'b101: begin ctrl.shift = 1'b1; ctrl.shift_type = SH_SRL; end
              3'b110: ctrl.alu_op = ALU_OR;
              default: ctrl.alu_op = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'b000:  ctrl.alu_op = ALU_SUB;
              3'b101:  begin ctrl.shift = 1'b1; ctrl.shift_type = SH_SRA; end
              default: illegal = 1'b1;
            endcase
          end
          7'b0000001: begin
`ifdef RV_M_EXT_EN
            ctrl.alu_op = ALU_MULDIV;
`else
            illegal = 1'b1;
`endif
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_MISC_MEM: begin
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      OPC_SYSTEM: begin
        if (instr != 32'h0000_0073 && instr != 32'h0010_0073) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    ctrl.illegal = illegal;
    if (illegal) begin
      ctrl.reg_write = 1'b0;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
    end
  end

  assign imm_full = make_imm(instr, imm_type);
  assign imm      = imm_full[XLEN-1:0];

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one-cycle decode into a main register backed by a single skid entry,
// with flush and a saturating illegal-instruction counter.
module decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output ctrl_t            out_ctrl,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_count
);

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  logic            skid_valid;
  ctrl_t           skid_ctrl;
  logic [XLEN-1:0] skid_imm;
  logic [XLEN-1:0] skid_pc;

  logic in_xfer, out_xfer, main_free;
  logic main_valid_nxt, skid_valid_nxt;
  logic load_main_skid, load_main_in, load_skid;

  rv_decoder #(.XLEN(XLEN)) u_decoder (
    .instr (in_instr),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign main_free = !out_valid || out_ready;

  // in_ready tracks !skid_valid, so the skid is never occupied while an input is accepted.
  always_comb begin
    main_valid_nxt = out_valid;
    skid_valid_nxt = skid_valid;
    load_main_skid = 1'b0;
    load_main_in   = 1'b0;
    load_skid      = 1'b0;
    if (main_free) begin
      if (skid_valid) begin
        main_valid_nxt = 1'b1;
        skid_valid_nxt = 1'b0;
        load_main_skid = 1'b1;
      end else begin
        main_valid_nxt = in_xfer;
        load_main_in   = in_xfer;
      end
    end else if (in_xfer) begin
      skid_valid_nxt = 1'b1;
      load_skid      = 1'b1;
    end
    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      skid_valid    <= 1'b0;
      in_ready      <= 1'b1;
      illegal_count <= '0;
      out_ctrl      <= '0;
      out_imm       <= '0;
      out_pc        <= '0;
      skid_ctrl     <= '0;
      skid_imm      <= '0;
      skid_pc       <= '0;
    end else begin
      out_valid  <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready   <= !skid_valid_nxt;
      if (load_main_skid) begin
        out_ctrl <= skid_ctrl;
        out_imm  <= skid_imm;
        out_pc   <= skid_pc;
      end else if (load_main_in) begin
        out_ctrl <= dec_ctrl;
        out_imm  <= dec_imm;
        out_pc   <= in_pc;
      end
      if (load_skid) begin
        skid_ctrl <= dec_ctrl;
        skid_imm  <= dec_imm;
        skid_pc   <= in_pc;
      end
      if (out_xfer && out_ctrl.illegal && illegal_count != '1)
        illegal_count <= illegal_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, skid backpressure, flush, reset and counter saturation.
module tb_decode_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid;
  ctrl_t       out_ctrl;
  logic [31:0] out_imm, out_pc;
  logic [7:0]  illegal_count;

  logic        in_ready64, out_valid64;
  ctrl_t       out_ctrl64;
  logic [63:0] out_imm64, out_pc64;
  logic [7:0]  illegal_count64;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_imm(out_imm), .out_pc(out_pc),
    .illegal_count(illegal_count)
  );

  decode_stage #(.XLEN(64), .CNT_W(8)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc({32'h0, in_pc}), .flush(flush), .out_valid(out_valid64),
    .out_ready(out_ready), .out_ctrl(out_ctrl64), .out_imm(out_imm64), .out_pc(out_pc64),
    .illegal_count(illegal_count64)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // flags = {reg_write, mem_read, mem_write, branch, illegal}
  task automatic apply_dec(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] e_imm, input logic [2:0] e_op,
                           input logic [4:0] e_flags, input logic [3:0] e_xfer);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    step();
    check_val({tag, "_valid"}, out_valid, 1);
    check_val({tag, "_pc"}, out_pc, pc);
    check_val({tag, "_imm"}, out_imm, e_imm);
    check_val({tag, "_aluop"}, out_ctrl.alu_op, e_op);
    check_val({tag, "_flags"}, {out_ctrl.reg_write, out_ctrl.mem_read, out_ctrl.mem_write,
                                out_ctrl.branch, out_ctrl.illegal}, e_flags);
    check_val({tag, "_xfer"}, out_ctrl.xfer_size, e_xfer);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step(); step();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_count", illegal_count, 0);
    check_val("rst_ctrl", out_ctrl, 0);
    check_val("rst_imm", out_imm, 0);
    check_val("rst_pc", out_pc, 0);
    reset = 1'b0;
    step();
    check_val("post_rst_valid", out_valid, 0);

    // addi x1,x0,5
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100;
    step();
    check_val("addi_valid", out_valid, 1);
    check_val("addi_imm", out_imm, 5);
    check_val("addi_aluop", out_ctrl.alu_op, 0);
    check_val("addi_alusrc", out_ctrl.alu_src, 1);
    check_val("addi_rw", out_ctrl.reg_write, 1);
    check_val("addi_rd", out_ctrl.rd, 1);
    check_val("addi_pc", out_pc, 32'h100);
    in_valid = 1'b0;
    step();
    check_val("addi_drained", out_valid, 0);

    // backpressure: A, B accepted, C held off by the full skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0010_0113; in_pc = 32'h200;
    step();
    check_val("bp_a_valid", out_valid, 1);
    check_val("bp_a_ready", in_ready, 1);
    in_instr = 32'h0020_0193; in_pc = 32'h204;
    step();
    check_val("bp_b_ready", in_ready, 0);
    check_val("bp_b_headpc", out_pc, 32'h200);
    in_instr = 32'h0030_0213; in_pc = 32'h208;
    step();
    check_val("bp_c_ready", in_ready, 0);
    check_val("bp_c_headpc", out_pc, 32'h200);
    out_ready = 1'b1;
    check_val("bp_a_out_valid", out_valid, 1);
    step();
    check_val("bp_b_out_pc", out_pc, 32'h204);
    check_val("bp_b_out_valid", out_valid, 1);
    check_val("bp_b_out_rd", out_ctrl.rd, 3);
    check_val("bp_ready_back", in_ready, 1);
    step();
    check_val("bp_c_out_pc", out_pc, 32'h208);
    check_val("bp_c_out_valid", out_valid, 1);
    check_val("bp_c_out_rd", out_ctrl.rd, 4);
    in_valid = 1'b0;
    step();
    check_val("bp_drained", out_valid, 0);

    // decode table, streaming with out_ready=1
    apply_dec("lui",  32'h1234_52B7, 32'h400, 32'h1234_5000, 3'd5, 5'b10000, 4'd4);
    apply_dec("sw",   32'h0020_A423, 32'h404, 32'h0000_0008, 3'd0, 5'b00100, 4'd4);
    apply_dec("lb",   32'hFFC0_8183, 32'h408, 32'hFFFF_FFFC, 3'd0, 5'b11000, 4'd1);
    apply_dec("beq",  32'hFE20_8CE3, 32'h40C, 32'hFFFF_FFF8, 3'd1, 5'b00010, 4'd4);
    apply_dec("sub",  32'h4020_81B3, 32'h410, 32'h0000_0000, 3'd1, 5'b10000, 4'd4);
    apply_dec("ld32", 32'hFFF0_B083, 32'h414, 32'hFFFF_FFFF, 3'd0, 5'b00001, 4'd4);
    exp_cnt = exp_cnt + 1;
    check_val("ld64_valid", out_valid64, 1);
    check_val("ld64_xfer", out_ctrl64.xfer_size, 8);
    check_val("ld64_memread", out_ctrl64.mem_read, 1);
    check_val("ld64_illegal", out_ctrl64.illegal, 0);
    check_val("ld64_imm", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("ld64_pc", out_pc64, 64'h414);
    check_val("ld64_ready", in_ready64, 1);
`ifdef RV_M_EXT_EN
    apply_dec("mul",  32'h0220_8033, 32'h418, 32'h0000_0000, 3'd6, 5'b10000, 4'd4);
    check_val("mul_alusrc", out_ctrl.alu_src, 0);
`else
    apply_dec("mul",  32'h0220_8033, 32'h418, 32'h0000_0000, 3'd0, 5'b00001, 4'd4);
    exp_cnt = exp_cnt + 1;
`endif
    in_valid = 1'b0;
    step();
    check_val("table_drained", out_valid, 0);
    check_val("table_count", illegal_count, exp_cnt);

    // flush with main and skid full and a new instruction offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000_0000; in_pc = 32'h300;
    step();
    in_pc = 32'h304;
    step();
    check_val("fl_full_ready", in_ready, 0);
    in_pc = 32'h308; flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("fl_valid", out_valid, 0);
    check_val("fl_ready", in_ready, 1);
    check_val("fl_count", illegal_count, exp_cnt);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_val("fl_nothing", out_valid, 0);
    // flush drops a same-cycle accepted input
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h310;
    step();
    in_pc = 32'h314; flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("fl2_valid", out_valid, 0);
    check_val("fl2_ready", in_ready, 1);
    out_ready = 1'b1; in_pc = 32'h318;
    step();
    check_val("fl2_next_valid", out_valid, 1);
    check_val("fl2_next_pc", out_pc, 32'h318);
    in_valid = 1'b0;
    step();
    check_val("fl2_drained", out_valid, 0);

    // 300 illegal instructions: counter saturates at 255
    in_valid = 1'b1; in_instr = 32'h0000_0000;
    for (int i = 1; i <= 300; i++) begin
      in_pc = 32'h1000 + 32'(i * 4);
      step();
      check_val("sat_illegal", out_ctrl.illegal, 1);
      check_val("sat_rw", out_ctrl.reg_write, 0);
      check_val("sat_count", illegal_count, ((exp_cnt + i - 1) > 255) ? 255 : (exp_cnt + i - 1));
    end
    in_valid = 1'b0;
    step();
    check_val("sat_final", illegal_count, 255);

    // reset with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h500;
    step();
    in_pc = 32'h504;
    step();
    check_val("mr_full", in_ready, 0);
    reset = 1'b1;
    step();
    check_val("mr_valid", out_valid, 0);
    check_val("mr_ready", in_ready, 1);
    check_val("mr_count", illegal_count, 0);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_val("mr_after_valid", out_valid, 0);
    check_val("mr_after_pc", out_pc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
